// File: rtl/voice_scheduler_pkg.sv
// Shared constants and FSM state type for the voice scheduler.
package conFFTi;

  localparam int unsigned NUM_VOICES = 4;
  localparam int unsigned SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/voice_scheduler_next_voice_finder.sv
// Priority encoder: lowest enabled voice index at or above start within the snapshot mask.
module next_voice_finder #(
  parameter int unsigned NUM_VOICES = 4,
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic [NUM_VOICES-1:0] mask,
  input  logic [IDX_W-1:0]      start,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found && mask[i] && (i >= 32'(start))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Per-frame voice scheduler: serialises enabled voices onto a shared datapath and sums the mix.
// VOICE_SCHEDULER_SKIP_IDLE_EN skips disabled voices in zero cycles instead of one slot each.
module voice_scheduler
  import conFFTi::*;
#(
  parameter int unsigned NUM_VOICES = conFFTi::NUM_VOICES,
  parameter int unsigned SAMPLE_W   = conFFTi::SAMPLE_W,
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic [NUM_VOICES-1:0]      notes_en,
  input  logic [NUM_VOICES*7-1:0]    notes,
  input  logic [NUM_VOICES*7-1:0]    velocities,
  output logic                       ds_req_valid,
  input  logic                       ds_req_ready,
  output logic [IDX_W-1:0]           ds_req_voice,
  output logic [6:0]                 ds_req_note,
  output logic [6:0]                 ds_req_velocity,
  input  logic                       ds_resp_valid,
  input  logic signed [SAMPLE_W-1:0] ds_resp_sample,
  output logic                       mix_valid,
  output logic signed [SAMPLE_W+1:0] mix_sample,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VOICES - 1);

  sched_state_t               state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_VOICES-1:0]      en_q;
  logic [NUM_VOICES*7-1:0]    notes_q, vel_q;
  logic signed [SAMPLE_W+1:0] acc_q, acc_d, mix_q;
  logic                       overrun_q;

  logic             found;
  logic [IDX_W-1:0] found_idx, cur_idx;
  logic             cur_en, last;

  next_voice_finder #(
    .NUM_VOICES(NUM_VOICES)
  ) u_finder (
    .mask (en_q),
    .start(idx_q),
    .found(found),
    .idx  (found_idx)
  );

`ifdef VOICE_SCHEDULER_SKIP_IDLE_EN
  assign cur_idx = found_idx;
  assign cur_en  = found;
`else
  // Fixed slot order: only the current slot is considered.
  assign cur_idx = idx_q;
  assign cur_en  = found && (found_idx == idx_q);
`endif

  assign last = (idx_q == LastIdx);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    ds_req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = ISSUE;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ISSUE: begin
        if (cur_en) begin
          ds_req_valid = 1'b1;
          if (ds_req_ready) begin
            idx_d   = cur_idx;
            state_d = WAIT;
          end
        end else begin
`ifdef VOICE_SCHEDULER_SKIP_IDLE_EN
          state_d = DONE;
`else
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 1'b1;
`endif
        end
      end
      WAIT: begin
        if (ds_resp_valid) begin
          acc_d = acc_q + (SAMPLE_W + 2)'(ds_resp_sample);
          if (last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      en_q      <= '0;
      notes_q   <= '0;
      vel_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      overrun_q <= sample_tick && (state_q != IDLE);
      if (state_q == IDLE && sample_tick) begin
        en_q    <= notes_en;
        notes_q <= notes;
        vel_q   <= velocities;
      end
      // Latch the final sum as DONE is entered so it is valid alongside mix_valid.
      if (state_d == DONE && state_q != DONE) mix_q <= acc_d;
    end
  end

  assign ds_req_voice    = cur_idx;
  assign ds_req_note     = notes_q[32'(cur_idx) * 7 +: 7];
  assign ds_req_velocity = vel_q[32'(cur_idx) * 7 +: 7];
  assign mix_valid       = (state_q == DONE);
  assign mix_sample      = mix_q;
  assign busy            = (state_q != IDLE);
  assign overrun         = overrun_q;

endmodule
